// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Register-programmed SPI master with software-controlled chip selects.
// One byte is exchanged per transfer, MSB first, as 16 half-periods of
// spi_clk, each lasting DIV+1 clk cycles.
//
// Optional feature macro: SPI_MASTER_MODES_EN
//   defined   : CTRL[3] (cpol) and CTRL[4] (cpha) select SPI modes 0..3.
//   undefined : CTRL[4:3] read 0 and ignore writes; mode 0 only.
//
// Register map (reg_addr):
//   0 DATA   write: load tx byte and start; read: last received byte
//   1 STATUS [0] busy (RO), [1] done (W1C), [2] overrun (W1C)
//   2 CTRL   [2:0] cs_en, [3] cpol, [4] cpha, [7] ie
//   3 DIV    half-period length minus 1
//   others read 0
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low
//   reg_addr     in   [4:0] register select
//   reg_data_in  in   [7:0] write data
//   reg_write    in   write strobe, one cycle per write
//   reg_data_out out  [7:0] combinational read data
//   spi_clk      out  serial clock
//   spi_mosi     out  serial data out
//   spi_miso     in   serial data in
//   spi_cs       out  [2:0] chip selects, active-low
//   interrupt    out  level interrupt (done & ie)
// -----------------------------------------------------------------------------
module spi_master (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] reg_addr,
    input  logic [7:0] reg_data_in,
    input  logic       reg_write,
    output logic [7:0] reg_data_out,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [2:0] spi_cs,
    output logic       interrupt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [4:0] ADDR_DATA   = 5'd0;
    localparam logic [4:0] ADDR_STATUS = 5'd1;
    localparam logic [4:0] ADDR_CTRL   = 5'd2;
    localparam logic [4:0] ADDR_DIV    = 5'd3;

    logic [0:0] r_state;
    logic [7:0] r_tx;
    logic [7:0] r_shift;
    logic [7:0] r_rx;
    logic [7:0] r_div;
    logic [7:0] r_cnt;
    logic [3:0] r_half;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_done;
    logic       r_ovr;
    logic       r_ie;
    logic [2:0] r_cs_en;

    logic w_cpol;
    logic w_cpha;
    logic w_busy;
    logic w_wr_data;
    logic w_wr_status;
    logic w_wr_ctrl;
    logic w_wr_div;
    logic w_last;
    logic w_lead;

    assign w_busy      = (r_state == ST_RUN);
    assign w_wr_data   = reg_write && (reg_addr == ADDR_DATA);
    assign w_wr_status = reg_write && (reg_addr == ADDR_STATUS);
    assign w_wr_ctrl   = reg_write && (reg_addr == ADDR_CTRL);
    assign w_wr_div    = reg_write && (reg_addr == ADDR_DIV);
    assign w_last      = (r_half == 4'd15);
    // Half-periods are counted from 0, so the edge ending an even-indexed
    // half-period is an odd-numbered (leading) edge.
    assign w_lead      = ~r_half[0];

`ifdef SPI_MASTER_MODES_EN
    logic r_cpol;
    logic r_cpha;

    // Mode bits are frozen while a transfer is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
        end else if (w_wr_ctrl && !w_busy) begin
            r_cpol <= reg_data_in[3];
            r_cpha <= reg_data_in[4];
        end
    end

    assign w_cpol = r_cpol;
    assign w_cpha = r_cpha;
`else
    assign w_cpol = 1'b0;
    assign w_cpha = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tx    <= 8'h00;
            r_shift <= 8'h00;
            r_rx    <= 8'h00;
            r_div   <= 8'h00;
            r_cnt   <= 8'h00;
            r_half  <= 4'd0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_ie    <= 1'b0;
            r_cs_en <= 3'b000;
        end else begin
            if (w_wr_ctrl) begin
                r_cs_en <= reg_data_in[2:0];
                r_ie    <= reg_data_in[7];
            end
            if (w_wr_div && !w_busy) begin
                r_div <= reg_data_in;
            end

            // W1C first; any set later in this block takes priority.
            if (w_wr_status && reg_data_in[1]) begin
                r_done <= 1'b0;
            end
            if (w_wr_status && reg_data_in[2]) begin
                r_ovr <= 1'b0;
            end
            if (w_wr_data && w_busy) begin
                r_ovr <= 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_sclk <= w_cpol;
                if (w_wr_data) begin
                    r_state <= ST_RUN;
                    r_tx    <= reg_data_in;
                    r_cnt   <= r_div;
                    r_half  <= 4'd0;
                    // cpha=0 presents the MSB before the first edge; cpha=1
                    // waits for the first leading edge.
                    if (!w_cpha) begin
                        r_mosi <= reg_data_in[7];
                    end
                end
            end else begin
                if (r_cnt != 8'd0) begin
                    r_cnt <= r_cnt - 8'd1;
                end else begin
                    r_cnt <= r_div;
                    if (w_last) begin
                        // 16th half-period: clock returns to idle level; with
                        // cpha=1 this is the final trailing (sampling) edge.
                        r_state <= ST_IDLE;
                        r_sclk  <= w_cpol;
                        r_done  <= 1'b1;
                        r_rx    <= w_cpha ? {r_shift[6:0], spi_miso} : r_shift;
                    end else begin
                        r_half <= r_half + 4'd1;
                        r_sclk <= ~r_sclk;
                        if (w_lead) begin
                            if (w_cpha) begin
                                r_mosi <= r_tx[7];
                                r_tx   <= {r_tx[6:0], 1'b0};
                            end else begin
                                r_shift <= {r_shift[6:0], spi_miso};
                            end
                        end else begin
                            if (w_cpha) begin
                                r_shift <= {r_shift[6:0], spi_miso};
                            end else begin
                                r_mosi <= r_tx[6];
                                r_tx   <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        reg_data_out = 8'h00;
        case (reg_addr)
            ADDR_DATA:   reg_data_out = r_rx;
            ADDR_STATUS: reg_data_out = {5'b00000, r_ovr, r_done, w_busy};
            ADDR_CTRL:   reg_data_out = {r_ie, 2'b00, w_cpha, w_cpol, r_cs_en};
            ADDR_DIV:    reg_data_out = r_div;
            default:     reg_data_out = 8'h00;
        endcase
    end

    assign spi_clk   = r_sclk;
    assign spi_mosi  = r_mosi;
    assign spi_cs    = ~r_cs_en;
    assign interrupt = r_done & r_ie;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic       clk;
    logic       reset;
    logic [4:0] reg_addr;
    logic [7:0] reg_data_in;
    logic       reg_write;
    logic [7:0] reg_data_out;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [2:0] spi_cs;
    logic       interrupt;

    logic       tb_loop;
    logic       tb_miso;

    int n_vec;
    int n_err;

    assign spi_miso = tb_loop ? spi_mosi : tb_miso;

    spi_master dut (
        .clk          (clk),
        .reset        (reset),
        .reg_addr     (reg_addr),
        .reg_data_in  (reg_data_in),
        .reg_write    (reg_write),
        .reg_data_out (reg_data_out),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_cs       (spi_cs),
        .interrupt    (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_addr    = a;
        reg_data_in = d;
        reg_write   = 1'b1;
        @(negedge clk);
        reg_write   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        reg_addr = a;
        #1;
        d = reg_data_out;
    endtask

    // Counts negedges with busy=1, up to max.
    task automatic wait_idle(input int max, output int cyc);
        logic [7:0] s;
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            rd(5'd1, s);
            if (!s[0]) break;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (spi_cs !== 3'b111) begin
            n_err++; $display("FAIL reset_cs: got %b expected 111", spi_cs);
        end
        n_vec++;
        if ({spi_clk, spi_mosi, interrupt} !== 3'b000) begin
            n_err++; $display("FAIL reset_pins: got %b expected 000", {spi_clk, spi_mosi, interrupt});
        end
        reset = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            rd(a[4:0], d);
            n_vec++;
            if (d !== 8'h00) begin
                n_err++; $display("FAIL reset_reg%0d: got %h expected 00", a, d);
            end
        end
    endtask

    task automatic test_loopback_div0;
        logic [7:0] d;
        int cyc;
        tb_loop = 1'b1;
        wr(5'd3, 8'h00);
        wr(5'd2, 8'h00);
        wr(5'd0, 8'hA5);
        wait_idle(100, cyc);
        n_vec++;
        if (cyc !== 16) begin
            n_err++; $display("FAIL div0_busy: got %0d expected 16", cyc);
        end
        rd(5'd0, d);
        n_vec++;
        if (d !== 8'hA5) begin
            n_err++; $display("FAIL div0_rx: got %h expected a5", d);
        end
        rd(5'd1, d);
        n_vec++;
        if (d !== 8'h02) begin
            n_err++; $display("FAIL div0_status: got %h expected 02", d);
        end
        n_vec++;
        if ({spi_clk, interrupt} !== 2'b00) begin
            n_err++; $display("FAIL div0_idle_clk_irq: got %b expected 00", {spi_clk, interrupt});
        end
        rd(5'd9, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL unmapped_read: got %h expected 00", d);
        end
        wr(5'd1, 8'h02);
        rd(5'd1, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL done_clear: got %h expected 00", d);
        end
    endtask

    task automatic test_div3_waveform;
        logic       sclk_s [0:79];
        logic       mosi_s [0:79];
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] exp_tx;
        logic       lvl;
        logic       bad;
        int         cyc;
        tb_loop = 1'b0;
        tb_miso = 1'b1;
        exp_tx  = 8'b0011_1100;
        wr(5'd3, 8'h03);
        wr(5'd0, 8'h3C);
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            rd(5'd1, s);
            if (!s[0]) break;
            sclk_s[i] = spi_clk;
            mosi_s[i] = spi_mosi;
            cyc++;
            @(negedge clk);
        end
        n_vec++;
        if (cyc !== 64) begin
            n_err++; $display("FAIL div3_busy: got %0d expected 64", cyc);
        end
        if (cyc == 64) begin
            for (int k = 0; k < 16; k++) begin
                lvl = (k % 2) == 1;
                bad = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (sclk_s[4*k+j] !== lvl) bad = 1'b1;
                end
                n_vec++;
                if (bad) begin
                    n_err++; $display("FAIL div3_sclk_half%0d: got %b%b%b%b expected level %b",
                                      k, sclk_s[4*k], sclk_s[4*k+1], sclk_s[4*k+2], sclk_s[4*k+3], lvl);
                end
            end
            for (int b = 0; b < 8; b++) begin
                bad = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    if (mosi_s[8*b+j] !== exp_tx[7-b]) bad = 1'b1;
                end
                n_vec++;
                if (bad) begin
                    n_err++; $display("FAIL div3_mosi_bit%0d: got %b expected %b",
                                      b, mosi_s[8*b], exp_tx[7-b]);
                end
            end
        end
        rd(5'd0, d);
        n_vec++;
        if (d !== 8'hFF) begin
            n_err++; $display("FAIL div3_rx: got %h expected ff", d);
        end
        wr(5'd1, 8'h06);
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        int cyc;
        tb_loop = 1'b1;
        wr(5'd3, 8'h01);
        wr(5'd0, 8'h96);
        repeat (4) @(negedge clk);
        wr(5'd0, 8'h11);
        wait_idle(100, cyc);
        n_vec++;
        if (cyc >= 100) begin
            n_err++; $display("FAIL overrun_timeout: got %0d cycles busy expected under 100", cyc);
        end
        rd(5'd0, d);
        n_vec++;
        if (d !== 8'h96) begin
            n_err++; $display("FAIL overrun_rx: got %h expected 96", d);
        end
        rd(5'd1, d);
        n_vec++;
        if (d !== 8'h06) begin
            n_err++; $display("FAIL overrun_status: got %h expected 06", d);
        end
        wr(5'd1, 8'h06);
        rd(5'd1, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL overrun_clear: got %h expected 00", d);
        end
    endtask

    task automatic test_modes;
        logic [7:0] d;
        int cyc;
        tb_loop = 1'b1;
        wr(5'd2, 8'h18);
        @(negedge clk);
`ifdef SPI_MASTER_MODES_EN
        rd(5'd2, d);
        n_vec++;
        if (d !== 8'h18) begin
            n_err++; $display("FAIL mode3_ctrl: got %h expected 18", d);
        end
        n_vec++;
        if (spi_clk !== 1'b1) begin
            n_err++; $display("FAIL mode3_idle_clk: got %b expected 1", spi_clk);
        end
`else
        rd(5'd2, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL modes_off_ctrl: got %h expected 00", d);
        end
        n_vec++;
        if (spi_clk !== 1'b0) begin
            n_err++; $display("FAIL modes_off_idle_clk: got %b expected 0", spi_clk);
        end
`endif
        wr(5'd0, 8'h5A);
        wait_idle(100, cyc);
        n_vec++;
        if (cyc !== 32) begin
            n_err++; $display("FAIL modes_busy: got %0d expected 32", cyc);
        end
        rd(5'd0, d);
        n_vec++;
        if (d !== 8'h5A) begin
            n_err++; $display("FAIL modes_rx: got %h expected 5a", d);
        end
`ifdef SPI_MASTER_MODES_EN
        n_vec++;
        if (spi_clk !== 1'b1) begin
            n_err++; $display("FAIL mode3_clk_after: got %b expected 1", spi_clk);
        end
`endif
        wr(5'd2, 8'h00);
        wr(5'd1, 8'h06);
    endtask

    task automatic test_irq_and_reset;
        logic [7:0] d;
        tb_loop = 1'b1;
        wr(5'd3, 8'h00);
        wr(5'd2, 8'h80);
        wr(5'd1, 8'h06);
        // DATA write sampled on edge E0; the 16th half-period ends on E16.
        @(negedge clk);
        reg_addr = 5'd0; reg_data_in = 8'hC3; reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
        repeat (15) @(negedge clk);
        reg_addr = 5'd1; reg_data_in = 8'h02; reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
        rd(5'd1, d);
        n_vec++;
        if (d !== 8'h02) begin
            n_err++; $display("FAIL irq_w1c_collide_status: got %h expected 02", d);
        end
        n_vec++;
        if (interrupt !== 1'b1) begin
            n_err++; $display("FAIL irq_level: got %b expected 1", interrupt);
        end

        wr(5'd2, 8'h87);
        wr(5'd3, 8'h03);
        wr(5'd0, 8'hFF);
        repeat (6) @(negedge clk);
        n_vec++;
        if ({spi_clk, spi_mosi, spi_cs, interrupt} !== 6'b11_000_1) begin
            n_err++; $display("FAIL pre_abort_pins: got %b expected 110001",
                              {spi_clk, spi_mosi, spi_cs, interrupt});
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({spi_clk, spi_mosi, spi_cs, interrupt} !== 6'b00_111_0) begin
            n_err++; $display("FAIL abort_pins: got %b expected 001110",
                              {spi_clk, spi_mosi, spi_cs, interrupt});
        end
        reset = 1'b1;
        @(negedge clk);
        rd(5'd1, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL abort_status: got %h expected 00", d);
        end
    endtask

    task automatic test_cs_div_lock;
        logic [7:0] d;
        int cyc;
        tb_loop = 1'b1;
        wr(5'd2, 8'h05);
        n_vec++;
        if (spi_cs !== 3'b010) begin
            n_err++; $display("FAIL cs_pattern: got %b expected 010", spi_cs);
        end
        wr(5'd3, 8'h00);
        wr(5'd0, 8'h81);
        wr(5'd3, 8'h09);
        wr(5'd2, 8'h1A);
        rd(5'd3, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL div_locked: got %h expected 00", d);
        end
        rd(5'd2, d);
        n_vec++;
        if (d !== 8'h02) begin
            n_err++; $display("FAIL ctrl_busy_write: got %h expected 02", d);
        end
        n_vec++;
        if (spi_cs !== 3'b101) begin
            n_err++; $display("FAIL cs_busy_write: got %b expected 101", spi_cs);
        end
        wait_idle(100, cyc);
        rd(5'd0, d);
        n_vec++;
        if (d !== 8'h81) begin
            n_err++; $display("FAIL cs_div_rx: got %h expected 81", d);
        end
        wr(5'd3, 8'h09);
        rd(5'd3, d);
        n_vec++;
        if (d !== 8'h09) begin
            n_err++; $display("FAIL div_idle_write: got %h expected 09", d);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b0;
        reg_addr    = 5'd0;
        reg_data_in = 8'h00;
        reg_write   = 1'b0;
        tb_loop     = 1'b0;
        tb_miso     = 1'b0;

        test_reset;
        test_loopback_div0;
        test_div3_waveform;
        test_overrun;
        test_modes;
        test_irq_and_reset;
        test_cs_div_lock;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low; 0 sampled on a clk edge resets the block.
REQ-003 SHALL have ports: reg_addr  in  5  register select; reg_data_in  in  8  write data; reg_write  in  1  write strobe, one cycle per write.
REQ-004 SHALL have ports: reg_data_out  out  8  combinational read data; unmapped addresses read 0.
REQ-005 SHALL have ports: spi_clk  out  1  serial clock; spi_mosi  out  1  serial data out; spi_miso  in  1  serial data in (already routed by the pin mux).
REQ-006 SHALL have ports: spi_cs  out  3  chip selects, active-low; interrupt  out  1  level interrupt.

Function
REQ-007 SHALL decode these registers. 0 DATA: a write loads the tx byte and starts a transfer; a read returns the last rx byte. 1 STATUS: [0] busy (RO), [1] done (W1C), [2] overrun (W1C). 2 CTRL: [2:0] cs_en, [3] cpol, [4] cpha, [7] ie. 3 DIV: half-period length minus 1.
REQ-008 SHALL drive spi_cs[i] = ~cs_en[i] at all times; CS is software controlled and unaffected by transfers.
REQ-009 SHALL implement states IDLE and RUN; a DATA write in IDLE moves to RUN, with busy=1 from the next cycle.
REQ-010 SHALL hold each half-period for DIV+1 clk cycles using an 8-bit down-counter; DIV=0 gives spi_clk = clk/2.
REQ-011 SHALL run exactly 16 half-periods per transfer, MSB first, with spi_clk toggling at the end of each of half-periods 1..15 and returning to cpol after the 16th.
REQ-012 SHALL, with cpha=0, present tx[7] on spi_mosi on entry to RUN, sample spi_miso on leading (odd) edges, and shift mosi on trailing (even) edges.
REQ-013 SHALL, with cpha=1, update spi_mosi on leading edges (first one presents tx[7]) and sample spi_miso on trailing edges.
REQ-014 SHALL, in the cycle the 16th half-period ends, load the rx byte, set done, clear busy and return to IDLE; total busy time is 16*(DIV+1) cycles.
REQ-015 SHALL ignore a DATA write while busy (tx and the transfer are untouched) and set overrun.
REQ-016 SHALL ignore writes to DIV and to CTRL[4:3] while busy; CTRL[2:0] and CTRL[7] are always writable.
REQ-017 SHALL give set priority when completion and a W1C of done occur in the same cycle (done stays 1).
REQ-018 SHALL drive interrupt = done & ie, registered-state only (no combinational path from inputs).
REQ-019 SHALL hold spi_mosi at the last driven bit and spi_clk at cpol while IDLE.

Reset
REQ-020 SHALL, on reset=0, enter IDLE and clear busy, done, overrun, cs_en, cpol, cpha, ie, DIV, tx and rx to 0.
REQ-021 SHALL, on reset mid-transfer, abort immediately: spi_clk=0, spi_mosi=0, spi_cs=3'b111 and interrupt=0 in the first cycle after the reset edge.

Configuration
REQ-022 SHALL honour macro SPI_MASTER_MODES_EN. When defined, cpol/cpha behave per REQ-011 to REQ-013. When undefined, CTRL[4:3] read 0 and ignore writes, and the block operates only in mode 0 (cpol=0, cpha=0).

Verification
REQ-023 SHALL cover: DIV=0, mode 0, spi_miso looped to spi_mosi, write DATA=0xA5 -> busy for 16 cycles, then DATA reads 0xA5 and STATUS=0x02.
REQ-024 SHALL cover: DIV=3, miso tied 1, write 0x3C -> each spi_clk level lasts 4 cycles, busy for 64 cycles, mosi sequence 0,0,1,1,1,1,0,0, rx=0xFF.
REQ-025 SHALL cover: mid-transfer DATA write 0x11 -> transfer still completes with the original byte, STATUS=0x06, and a write of 0x06 to STATUS clears it to 0.
REQ-026 SHALL cover (SPI_MASTER_MODES_EN): cpol=1, cpha=1, loopback, write 0x5A -> idle spi_clk=1, rx=0x5A.
REQ-027 SHALL cover: ie=1 with completion coinciding with a W1C of done -> done=1 and interrupt=1; then reset=0 mid-transfer -> all outputs take their REQ-021 values next cycle.
REQ-028 SHALL cover: CTRL=0x05 -> spi_cs=3'b010, and a DIV write while busy leaves DIV unchanged.
